// File: rtl/riscv_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 request port between NUM_REQ L1 requesters.
// Latency: strobe one cycle after request, response one cycle after l2_ready, 3 cycles minimum.
// Backpressure: one transaction in flight; others hold their level requests until their rsp_ready pulse.
module riscv_l2_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_read,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*32-1:0]      req_addr,
    input  logic [NUM_REQ*32-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         rsp_ready,
    output logic                       rsp_err,
    output logic [31:0]                rsp_rdata,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic [31:0]                l2_addr,
    output logic [31:0]                l2_wdata,
    output logic                       l2_read,
    output logic                       l2_write,
    input  logic [31:0]                l2_rdata,
    input  logic                       l2_ready
);

    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [CNT_W-1:0]   wdog;

    logic [NUM_REQ-1:0] active;
    logic [NUM_REQ-1:0] rot;
    logic               win_vld;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_id;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic               win_rd;
    logic               win_wr;
    logic [ID_W-1:0]    rr_next;
    logic               wdog_exp;

    assign active = req_read | req_write;

    // Rotating the request vector by rr_ptr turns the round-robin search into a lowest-bit search.
    assign rot = NUM_REQ'({active, active} >> rr_ptr);

    always_comb begin
        win_vld = 1'b0;
        win_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                win_vld = 1'b1;
                win_sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            end
        end
        if (win_sum >= (ID_W + 1)'(NUM_REQ)) begin
            win_sum = win_sum - (ID_W + 1)'(NUM_REQ);
        end
        win_id = win_sum[ID_W-1:0];
    end

    always_comb begin
        win_addr  = '0;
        win_wdata = '0;
        win_rd    = 1'b0;
        win_wr    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_addr  = req_addr[i*32 +: 32];
                win_wdata = req_wdata[i*32 +: 32];
                win_rd    = req_read[i];
                win_wr    = req_write[i];
            end
        end
    end

    assign rr_next  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign wdog_exp = (TIMEOUT != 0) && (wdog == CNT_W'(TIMEOUT - 1));
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            wdog      <= '0;
            grant_id  <= '0;
            l2_addr   <= '0;
            l2_wdata  <= '0;
            l2_read   <= 1'b0;
            l2_write  <= 1'b0;
            rsp_ready <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        l2_addr  <= win_addr;
                        l2_wdata <= win_wdata;
                        grant_id <= win_id;
                        // A requester raising both strobes is treated as a write.
                        l2_write <= win_wr;
                        l2_read  <= win_rd & ~win_wr;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    wdog <= wdog + CNT_W'(1);
                    if (l2_ready || wdog_exp) begin
                        rsp_ready <= NUM_REQ'(1) << grant_id;
                        rsp_err   <= ~l2_ready;
                        rsp_rdata <= (l2_ready && !l2_write) ? l2_rdata : '0;
                        l2_read   <= 1'b0;
                        l2_write  <= 1'b0;
                        rr_ptr    <= rr_next;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rsp_ready <= '0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    wdog      <= '0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_l2_port_arbiter.sv
// Randomized bench for riscv_l2_port_arbiter against a transaction-level reference model.
module tb_riscv_l2_port_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    rsp_ready;
    logic            rsp_err;
    logic [31:0]     rsp_rdata;
    logic            grant_id;
    logic            busy;
    logic [31:0]     l2_addr;
    logic [31:0]     l2_wdata;
    logic            l2_read;
    logic            l2_write;
    logic [31:0]     l2_rdata;
    logic            l2_ready;

    riscv_l2_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .grant_id(grant_id), .busy(busy),
        .l2_addr(l2_addr), .l2_wdata(l2_wdata),
        .l2_read(l2_read), .l2_write(l2_write),
        .l2_rdata(l2_rdata), .l2_ready(l2_ready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester-side model: pending transaction per requester plus arbitration history.
    bit          m_rd[N];
    bit          m_wr[N];
    logic [31:0] m_addr[N];
    logic [31:0] m_wdata[N];
    int          m_wait[N];
    int          m_rr;
    int          m_last;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_read[i]           = m_rd[i];
            req_write[i]          = m_wr[i];
            req_addr[i*32 +: 32]  = m_addr[i];
            req_wdata[i*32 +: 32] = m_wdata[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) begin
            m_rd[i] = 1'b0; m_wr[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_wait[i] = 0;
        end
        drive_reqs();
    endtask

    task automatic arrive();
        int kind;
        for (int i = 0; i < N; i++) begin
            if (!(m_rd[i] || m_wr[i]) && $urandom_range(0, 1) == 1) begin
                kind       = $urandom_range(0, 2);
                m_rd[i]    = (kind != 1);
                m_wr[i]    = (kind != 0);
                m_addr[i]  = $urandom;
                m_wdata[i] = $urandom;
                m_wait[i]  = 0;
            end
        end
    endtask

    // First pending requester at or after the round-robin pointer.
    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (m_rd[(m_rr + k) % N] || m_wr[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic idle_cycle();
        l2_ready = 1'b1;
        l2_rdata = $urandom;
        @(posedge clk); #1;
        l2_ready = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_l2_read", l2_read, 0);
        chk("idle_l2_write", l2_write, 0);
        chk("idle_grant", grant_id, m_last);
        chk("idle_rsp_ready", rsp_ready, 0);
    endtask

    // Entered in IDLE just after an edge with requests already driven; leaves in IDLE.
    task automatic do_txn(input int lat, input int rst_at, input bit drop, input bit mutate,
                          input logic [31:0] rdat);
        int w, c;
        bit ewr, erd, eerr, fin, aborted;
        logic [31:0] ea, ed;
        w = pick();
        if (w < 0) return;
        ewr = m_wr[w];
        erd = m_rd[w] && !m_wr[w];
        ea  = m_addr[w];
        ed  = m_wdata[w];
        @(posedge clk); #1;
        chk("grant_id", grant_id, w);
        chk("l2_read", l2_read, erd);
        chk("l2_write", l2_write, ewr);
        chk("l2_addr", l2_addr, ea);
        chk("l2_wdata", l2_wdata, ed);
        chk("busy_on", busy, 1);
        chk("rsp_ready_early", rsp_ready, 0);
        if (drop) begin m_rd[w] = 1'b0; m_wr[w] = 1'b0; end
        if (mutate) begin m_addr[w] = $urandom; m_wdata[w] = $urandom; end
        arrive();
        drive_reqs();
        c = 0; fin = 0; aborted = 0;
        while (!fin) begin
            chk("hold_addr", l2_addr, ea);
            chk("hold_read", l2_read, erd);
            chk("hold_write", l2_write, ewr);
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                chk("rst_l2_read", l2_read, 0);
                chk("rst_l2_write", l2_write, 0);
                chk("rst_busy", busy, 0);
                chk("rst_grant", grant_id, 0);
                @(posedge clk); #1;
                chk("rst_no_rsp", rsp_ready, 0);
                rst = 1'b0;
                m_rr = 0; m_last = 0;
                for (int i = 0; i < N; i++) m_wait[i] = 0;
                aborted = 1; fin = 1;
            end else begin
                if (c == lat) begin l2_ready = 1'b1; l2_rdata = rdat; end
                @(posedge clk); #1;
                l2_ready = 1'b0;
                if (c == lat || c == TO - 1) fin = 1;
                c++;
            end
        end
        if (aborted) return;
        eerr = (lat >= TO);
        chk("rsp_ready", rsp_ready, 32'(1) << w);
        chk("rsp_err", rsp_err, eerr);
        chk("rsp_rdata", rsp_rdata, (eerr || ewr) ? 32'h0 : rdat);
        chk("done_l2_read", l2_read, 0);
        chk("done_l2_write", l2_write, 0);
        chk("done_busy", busy, 1);
        chk("fair_wait", 32'(m_wait[w] <= N - 1), 1);
        for (int i = 0; i < N; i++) if (i != w && (m_rd[i] || m_wr[i])) m_wait[i]++;
        m_wait[w] = 0;
        m_rr = (w + 1) % N;
        m_last = w;
        m_rd[w] = 1'b0; m_wr[w] = 1'b0;
        drive_reqs();
        @(posedge clk); #1;
        chk("after_rsp_ready", rsp_ready, 0);
        chk("after_rsp_err", rsp_err, 0);
        chk("after_rsp_rdata", rsp_rdata, 0);
        chk("after_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; l2_ready = 1'b0; l2_rdata = '0;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_rr = 0; m_last = 0;
        clear_reqs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_ready", rsp_ready, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_l2_read", l2_read, 0);
        chk("rst_l2_write", l2_write, 0);
        chk("rst_l2_addr", l2_addr, 0);
        chk("rst_l2_wdata", l2_wdata, 0);
        rst = 1'b0;

        // Single read from the D-side requester.
        m_rd[1] = 1'b1; m_addr[1] = 32'h0000_1040;
        drive_reqs();
        do_txn(3, -1, 0, 0, 32'hDEAD_BEEF);

        // Stray l2_ready with nobody requesting.
        idle_cycle();
        idle_cycle();

        // Both requesters hold reads: grants alternate.
        clear_reqs();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) if (!m_rd[i]) begin m_rd[i] = 1'b1; m_addr[i] = 32'h100 * (i + 1) + t; end
            drive_reqs();
            do_txn(0, -1, 0, 0, $urandom);
        end

        // Read and write together: write wins, no read data returned.
        clear_reqs();
        m_rd[0] = 1'b1; m_wr[0] = 1'b1; m_addr[0] = 32'h2000; m_wdata[0] = 32'h1234_5678;
        drive_reqs();
        do_txn(2, -1, 0, 0, 32'hFFFF_0000);

        // L2 never answers.
        m_rd[1] = 1'b1; m_addr[1] = 32'h3000;
        drive_reqs();
        do_txn(100, -1, 0, 0, 32'h5555_AAAA);

        // Reset two cycles into BUSY, then the held request is served again.
        m_rd[0] = 1'b1; m_addr[0] = 32'h4000;
        drive_reqs();
        do_txn(100, 2, 0, 0, 32'h0);
        do_txn(1, -1, 0, 0, 32'hCAFE_F00D);

        // Request withdrawn during BUSY still completes once.
        m_rd[1] = 1'b1; m_addr[1] = 32'h5000;
        drive_reqs();
        do_txn(3, -1, 1, 1, 32'h0BAD_C0DE);

        repeat (250) begin
            arrive();
            drive_reqs();
            if (pick() < 0) idle_cycle();
            else do_txn($urandom_range(0, 10), -1, $urandom_range(0, 5) == 0,
                        $urandom_range(0, 3) == 0, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_l2_port_arbiter.md
Name: riscv_l2_port_arbiter

Overview:
- Shares the single L2 request port between NUM_REQ L1 requesters (requester 0 = L1 I-cache miss path, requester 1 = L1 D-cache miss/write-through path).
- Round-robin arbitration with one outstanding L2 transaction at a time.
- Registers the granted request, holds it on the L2 port until l2_ready, then returns the response to the winner.
- A watchdog aborts transactions that L2 never completes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT, 255, maximum BUSY cycles before abort; 0 disables the watchdog.
- CNT_W, 8, watchdog counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_read  in  NUM_REQ  per-requester read request; level, held until rsp_ready.
- req_write  in  NUM_REQ  per-requester write request; level, held until rsp_ready.
- req_addr  in  NUM_REQ*32  per-requester address; slice i = bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  per-requester write data; same slicing.
- rsp_ready  out  NUM_REQ  one-hot, one-cycle completion pulse to the winner.
- rsp_err  out  1  high with rsp_ready when the transaction timed out.
- rsp_rdata  out  32  read data; valid while rsp_ready is high.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last winner.
- busy  out  1  high in BUSY and DONE.
- l2_addr, l2_wdata  out  32 each  registered request to L2.
- l2_read, l2_write  out  1 each  registered strobes to L2.
- l2_rdata  in  32  L2 read data.
- l2_ready  in  1  L2 completion, one-cycle pulse.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset state: FSM = IDLE; rr_ptr = 0; watchdog = 0. All outputs are 0, including l2_read, l2_write, l2_addr, l2_wdata, rsp_*, grant_id and busy.
- Reset mid-transaction: L2 strobes drop immediately. No response is issued. The pending request is re-arbitrated after reset.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - A requester is active when req_read[i] | req_write[i].
  - Winner = first active index searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - If any requester is active, on the next edge: latch the winner's addr and wdata into l2_addr/l2_wdata; set grant_id; set l2_write = req_write[w]; set l2_read = req_read[w] & ~req_write[w] (write wins when both are set); go to BUSY.
  - l2_ready is ignored in IDLE.
- BUSY:
  - l2_* held stable; watchdog increments each cycle.
  - On l2_ready: rsp_rdata <= l2_rdata (write transactions give 0); rsp_ready[grant_id] <= 1; l2_read/l2_write <= 0; rr_ptr <= (grant_id+1) mod NUM_REQ; go to DONE.
  - Else if TIMEOUT != 0 and watchdog == TIMEOUT-1: same exit, but rsp_rdata <= 0 and rsp_err <= 1.
- DONE:
  - rsp_ready/rsp_err are high for exactly this cycle; no arbitration occurs.
  - The requester deasserts its request here.
  - Next edge: clear rsp_*, clear watchdog, go to IDLE.
- Latency:
  - Request seen in IDLE at cycle N drives the L2 strobe from N+1.
  - If l2_ready arrives at cycle N+k, rsp_ready is high at N+k+1.
  - Minimum of 3 cycles per transaction.
- Request dropped while BUSY: ignored; the transaction completes and the response is still pulsed.
- Request changing while BUSY: ignored; latched values are used.
- Fairness: a requester that holds its request waits at most NUM_REQ-1 transactions.
- Simultaneous requests with rr_ptr=0: requester 0 is granted first, then requester 1.
- rr_ptr advances only on completion or timeout, never on idle cycles.

Test Plan:
- Single read: req_read[1]=1, addr=0x0000_1040; l2_ready pulses 4 cycles after l2_read rises with l2_rdata=0xDEAD_BEEF -> l2_addr=0x0000_1040; rsp_ready=2'b10 one cycle later with rsp_rdata=0xDEAD_BEEF; grant_id=1.
- Contention: both requesters hold reads from reset, L2 answers in 1 cycle -> grant order 0,1,0,1; each rsp_ready is one-hot; no back-to-back grant to the same requester.
- Read+write on the same requester: req_read[0]=req_write[0]=1, wdata=0x1234_5678 -> l2_write=1, l2_read=0, l2_wdata=0x1234_5678; rsp_rdata=0.
- Timeout: TIMEOUT=8, l2_ready never arrives -> l2_read is high for exactly 8 cycles; rsp_ready and rsp_err are both high for 1 cycle; rsp_rdata=0; rr_ptr advances.
- Reset mid-BUSY: assert rst 2 cycles into BUSY -> l2_read=0 in the same cycle; no rsp_ready; after release the held request is re-granted and completes normally.
- Stray l2_ready in IDLE and a request dropped during BUSY -> no state change in IDLE; the dropped transaction still pulses rsp_ready exactly once.
